// File: rtl/registrador_coluna_pkg.sv
// registrador_coluna_pkg: mode encodings shared by the universal column register and its bench
package registrador_coluna_pkg;
  localparam logic [1:0] MODO_CARREGAR = 2'b00;
  localparam logic [1:0] MODO_ESQ_DIR  = 2'b01;
  localparam logic [1:0] MODO_DIR_ESQ  = 2'b10;
  localparam logic [1:0] MODO_ESPECIAL = 2'b11;
endpackage

// File: rtl/registrador_coluna_universal_mux.sv
// mux_modo_coluna: 4x1 per-bit next-value selector indexed by the mode code
// Ports: sel_i mode code; d0_i load, d1_i left-to-right, d2_i right-to-left, d3_i special; y_o selected bit
module mux_modo_coluna (
  input  logic [1:0] sel_i,
  input  logic       d0_i,
  input  logic       d1_i,
  input  logic       d2_i,
  input  logic       d3_i,
  output logic       y_o
);
  always_comb y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);
endmodule

// File: rtl/registrador_coluna_universal.sv
// registrador_coluna_universal: universal shift register with load, bidirectional shift, shift counter and completion pulse
// Ports: clock, reset_n (async active-low); habilitar enable; ch mode; definir_valores load value;
// entrada_esq/entrada_dir serial inputs; saida contents; saida_serial last bit out; contagem shifts since load; completo pulse.
// Macro REGISTRADOR_ROTACAO_EN: mode 11 rotates right and counts as a shift; otherwise mode 11 holds.
module registrador_coluna_universal
  import registrador_coluna_pkg::*;
#(
  parameter int                 LARGURA     = 8,
  parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             habilitar,
  input  logic [1:0]                       ch,
  input  logic [LARGURA-1:0]               definir_valores,
  input  logic                             entrada_esq,
  input  logic                             entrada_dir,
  output logic [LARGURA-1:0]               saida,
  output logic                             saida_serial,
  output logic [$clog2(LARGURA+1)-1:0]     contagem,
  output logic                             completo
);
  localparam int CW = $clog2(LARGURA+1);
`ifdef REGISTRADOR_ROTACAO_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic [LARGURA-1:0] saida_q, saida_d, prox_v, esq_v, dir_v, esp_v;
  logic               serial_q, serial_d, comp_q, comp_d, desloca, carregar;
  logic [CW-1:0]      cont_q, cont_d;
  assign esq_v = {entrada_esq, saida_q[LARGURA-1:1]};
  assign dir_v = {saida_q[LARGURA-2:0], entrada_dir};
  assign esp_v = ROT ? {saida_q[0], saida_q[LARGURA-1:1]} : saida_q;
  for (genvar i = 0; i < LARGURA; i++) begin : g_bit
    mux_modo_coluna u_mux (
      .sel_i(ch),
      .d0_i (definir_valores[i]),
      .d1_i (esq_v[i]),
      .d2_i (dir_v[i]),
      .d3_i (esp_v[i]),
      .y_o  (prox_v[i])
    );
  end
  always_comb begin
    carregar = habilitar && ch == MODO_CARREGAR;
    desloca  = habilitar && (ch == MODO_ESQ_DIR || ch == MODO_DIR_ESQ || (ROT && ch == MODO_ESPECIAL));
    saida_d  = habilitar ? prox_v : saida_q;
    serial_d = !habilitar ? serial_q :
               (ch == MODO_ESQ_DIR || (ROT && ch == MODO_ESPECIAL)) ? saida_q[0] :
               ch == MODO_DIR_ESQ ? saida_q[LARGURA-1] : serial_q;
    cont_d   = carregar ? '0 : (desloca && cont_q != CW'(LARGURA)) ? cont_q + CW'(1) : cont_q;
    // pulse only on the LARGURA-1 -> LARGURA transition, never while saturated
    comp_d   = desloca && cont_q == CW'(LARGURA-1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      saida_q  <= VALOR_RESET;
      serial_q <= 1'b0;
      cont_q   <= '0;
      comp_q   <= 1'b0;
    end else begin
      saida_q  <= saida_d;
      serial_q <= serial_d;
      cont_q   <= cont_d;
      comp_q   <= comp_d;
    end
  assign saida        = saida_q;
  assign saida_serial = serial_q;
  assign contagem     = cont_q;
  assign completo     = comp_q;
endmodule

// File: tb/tb_registrador_coluna_universal.sv
// tb_registrador_coluna_universal: scoreboard bench for the universal column register at LARGURA=4
module tb_registrador_coluna_universal;
  import registrador_coluna_pkg::*;
  typedef struct packed {
    logic [3:0] s;
    logic       ser;
    logic [2:0] c;
    logic       comp;
  } exp_t;
  logic       clock = 1'b0, reset_n = 1'b0, habilitar = 1'b0, entrada_esq = 1'b0, entrada_dir = 1'b0;
  logic [1:0] ch = 2'b00;
  logic [3:0] definir_valores = 4'h0, saida;
  logic       saida_serial, completo;
  logic [2:0] contagem;
  int         n_cmp = 0, n_err = 0;
  exp_t       fila[$];
  logic [3:0] m_s = 4'h0;
  logic       m_ser = 1'b0, m_comp = 1'b0;
  logic [2:0] m_c = 3'd0;
  registrador_coluna_universal #(.LARGURA(4), .VALOR_RESET(4'b0000)) dut (
    .clock(clock), .reset_n(reset_n), .habilitar(habilitar), .ch(ch),
    .definir_valores(definir_valores), .entrada_esq(entrada_esq), .entrada_dir(entrada_dir),
    .saida(saida), .saida_serial(saida_serial), .contagem(contagem), .completo(completo)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic desloca_modelo();
    m_comp = (m_c == 3'd3);
    if (m_c != 3'd4) m_c = m_c + 3'd1;
  endtask
  task automatic step(input logic h, input logic [1:0] m, input logic [3:0] dv, input logic e, input logic d, input string tag);
    exp_t got;
    @(negedge clock);
    habilitar = h; ch = m; definir_valores = dv; entrada_esq = e; entrada_dir = d;
    if (!h) m_comp = 1'b0;
    else if (m == MODO_CARREGAR) begin m_s = dv; m_c = 3'd0; m_comp = 1'b0; end
    else if (m == MODO_ESQ_DIR) begin m_ser = m_s[0]; m_s = {e, m_s[3:1]}; desloca_modelo(); end
    else if (m == MODO_DIR_ESQ) begin m_ser = m_s[3]; m_s = {m_s[2:0], d}; desloca_modelo(); end
    else begin
`ifdef REGISTRADOR_ROTACAO_EN
      m_ser = m_s[0]; m_s = {m_s[0], m_s[3:1]}; desloca_modelo();
`else
      m_comp = 1'b0;
`endif
    end
    fila.push_back('{s: m_s, ser: m_ser, c: m_c, comp: m_comp});
    @(posedge clock);
    #1;
    got = fila.pop_front();
    check({tag, ".saida"}, 32'(saida), 32'(got.s));
    check({tag, ".serial"}, 32'(saida_serial), 32'(got.ser));
    check({tag, ".contagem"}, 32'(contagem), 32'(got.c));
    check({tag, ".completo"}, 32'(completo), 32'(got.comp));
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".saida"}, 32'(saida), 32'h0);
    check({tag, ".serial"}, 32'(saida_serial), 32'h0);
    check({tag, ".contagem"}, 32'(contagem), 32'h0);
    check({tag, ".completo"}, 32'(completo), 32'h0);
    m_s = 4'h0; m_ser = 1'b0; m_c = 3'd0; m_comp = 1'b0;
  endtask
  initial begin
    #1 check_reset("rst");
    @(negedge clock) reset_n = 1'b1;
    step(1, MODO_CARREGAR, 4'b1011, 0, 0, "load");
    for (int i = 0; i < 5; i++) step(1, MODO_ESQ_DIR, 4'h0, 1, 0, "esq");
    step(1, MODO_CARREGAR, 4'b1011, 0, 0, "load2");
    for (int i = 0; i < 2; i++) step(1, MODO_DIR_ESQ, 4'h0, 0, 0, "dir");
    for (int i = 0; i < 3; i++) step(0, 2'(i), 4'hf, 1, 1, "hold");
    step(1, MODO_CARREGAR, 4'b0001, 0, 0, "load3");
    for (int i = 0; i < 2; i++) step(1, MODO_ESPECIAL, 4'h0, 1, 1, "esp");
    step(1, MODO_CARREGAR, 4'b1011, 0, 0, "load4");
    step(1, MODO_ESQ_DIR, 4'h0, 1, 0, "pre_rst");
    step(1, MODO_DIR_ESQ, 4'h0, 0, 1, "pre_rst");
    #2 reset_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clock) reset_n = 1'b1;
    step(1, MODO_CARREGAR, 4'b0101, 0, 0, "load5");
    for (int i = 0; i < 3; i++) step(1, MODO_ESQ_DIR, 4'h0, 0, 0, "cnt3");
    step(1, MODO_CARREGAR, 4'b0110, 0, 0, "load_wins");
    step(1, MODO_DIR_ESQ, 4'h0, 1, 1, "after_load");
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 1'($urandom), "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/registrador_coluna_universal.md
REGISTRADOR_COLUNA_UNIVERSAL -- requirements
Module: registrador_coluna_universal

Interface
REQ-001 Parameter LARGURA, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter VALOR_RESET, default 0, LARGURA-bit value loaded into saida on reset.
REQ-003 One clock; reset is asynchronous and active-low. Ports: clock in 1, rising-edge clock; reset_n in 1, async active-low reset.
REQ-004 habilitar  in  1  register update enable; 0 = full hold.
REQ-005 ch  in  2  mode select: 00 load, 01 esquerda_para_direita, 10 direita_para_esquerda, 11 per REQ-019.
REQ-006 definir_valores  in  LARGURA  parallel load value.
REQ-007 entrada_esq  in  1  serial bit entering at MSB in mode 01.
REQ-008 entrada_dir  in  1  serial bit entering at LSB in mode 10.
REQ-009 saida  out  LARGURA  register contents, registered.
REQ-010 saida_serial  out  1  last bit shifted out, registered.
REQ-011 contagem  out  $clog2(LARGURA+1)  shifts since last load, saturating.
REQ-012 completo  out  1  one-cycle pulse when contagem reaches LARGURA.

Function
REQ-013 All state SHALL update only on rising clock when habilitar=1; habilitar=0 holds saida, saida_serial, contagem and forces completo=0.
REQ-014 Mode 00: saida <= definir_valores; contagem <= 0; saida_serial unchanged; completo=0.
REQ-015 Mode 01: saida <= {entrada_esq, saida[LARGURA-1:1]}; saida_serial <= old saida[0].
REQ-016 Mode 10: saida <= {saida[LARGURA-2:0], entrada_dir}; saida_serial <= old saida[LARGURA-1].
REQ-017 Each shift cycle (modes 01, 10, and 11 when rotating) SHALL increment contagem by 1, saturating at LARGURA; no wrap.
REQ-018 completo SHALL be 1 for exactly the cycle following the edge where contagem goes LARGURA-1 -> LARGURA; further shifts at saturation produce no pulse.
REQ-019 Mode 11 SHALL follow REQ-025/REQ-026.
REQ-020 Load takes priority: load in the same cycle contagem would saturate yields contagem=0, completo=0.
REQ-021 Mode changes between 01 and 10 mid-sequence SHALL not reset contagem.
REQ-022 Latency: all outputs reflect the operation one clock after the sampling edge; no combinational input-to-output path.

Reset
REQ-023 reset_n=0 SHALL immediately (asynchronously) set saida=VALOR_RESET, saida_serial=0, contagem=0, completo=0, including mid-shift.
REQ-024 Release of reset_n SHALL be followed by normal operation from the next rising edge.

Configuration
REQ-025 With REGISTRADOR_ROTACAO_EN defined, mode 11 SHALL rotate right: saida <= {saida[0], saida[LARGURA-1:1]}; saida_serial <= old saida[0]; counts as a shift.
REQ-026 Without REGISTRADOR_ROTACAO_EN, mode 11 SHALL hold saida, saida_serial and contagem; completo=0.

Structure
REQ-027 Package registrador_coluna_pkg SHALL hold mode constants MODO_CARREGAR=00, MODO_ESQ_DIR=01, MODO_DIR_ESQ=10, MODO_ESPECIAL=11.
REQ-028 Per-bit next-value selection SHALL be a sub-module mux_modo_coluna (4x1, one instance per bit); counter and completo logic stay in the top module.

Verification (LARGURA=4, VALOR_RESET=4'b0000)
REQ-029 Reset then ch=00, definir_valores=4'b1011, habilitar=1 -> saida=4'b1011, contagem=0 next cycle.
REQ-030 From 4'b1011, ch=01, entrada_esq=1, 4 cycles -> saida sequence 1101,1110,1111,1111; saida_serial 1,1,0,1; completo=1 only after 4th shift; contagem=4 and stays 4 on a 5th shift with no pulse.
REQ-031 From 4'b1011, ch=10, entrada_dir=0, 2 cycles -> saida 0110,1100; saida_serial 1,0; contagem=2; then habilitar=0 for 3 cycles -> all outputs unchanged.
REQ-032 ch=11 from 4'b0001: with REGISTRADOR_ROTACAO_EN -> 1000 then 0100, contagem increments; without -> 0001 held, contagem unchanged.
REQ-033 reset_n asserted between clock edges after 2 shifts -> saida=0000, contagem=0, saida_serial=0 before the next edge.
REQ-034 contagem=3, ch=00 on the cycle a 4th shift would occur -> load wins, contagem=0, completo never pulses.
